mem_req: RTL and testbench

MEM_REQ -- requirements
Module: mem_req

---
 rtl/mem_req_pkg.sv | 30 +++
 rtl/store_align.sv | 67 ++++++
 rtl/mem_req.sv | 168 ++++++++++++++++
 tb/tb_mem_req.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared definitions for the data-memory request block: memop bit indices,
// FSM state encoding and SRAM-like size codes.
package mem_req_pkg;

    localparam int MMOP_W   = 12;
    localparam int MMOP_LB  = 0;
    localparam int MMOP_LBU = 1;
    localparam int MMOP_LH  = 2;
    localparam int MMOP_LHU = 3;
    localparam int MMOP_LW  = 4;
    localparam int MMOP_SB  = 5;
    localparam int MMOP_SH  = 6;
    localparam int MMOP_SW  = 7;
    localparam int MMOP_LWL = 8;
    localparam int MMOP_LWR = 9;
    localparam int MMOP_SWL = 10;
    localparam int MMOP_SWR = 11;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/store_align.sv
// Combinational decode of a memop: bus size, write flag, aligned address,
// byte strobes, lane-aligned store data and address-error detection.
module store_align
    import mem_req_pkg::*;
(
    input  logic [11:0] memop,
    input  logic [31:0] addr,
    input  logic [31:0] rt,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] bus_addr,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        adel,
    output logic        ades
);

    logic [1:0] low_s;
    logic       unaligned_op_s;

    assign low_s          = addr[1:0];
    assign unaligned_op_s = memop[MMOP_LWL] | memop[MMOP_LWR] | memop[MMOP_SWL] | memop[MMOP_SWR];

    // Decode request attributes from the one-hot memop.
    always_comb begin
        wr       = memop[MMOP_SB] | memop[MMOP_SH] | memop[MMOP_SW] | memop[MMOP_SWL] | memop[MMOP_SWR];
        bus_addr = unaligned_op_s ? {addr[31:2], 2'b00} : addr;
        adel     = ((memop[MMOP_LH] | memop[MMOP_LHU]) & addr[0]) | (memop[MMOP_LW] & (low_s != 2'b00));
        ades     = (memop[MMOP_SH] & addr[0]) | (memop[MMOP_SW] & (low_s != 2'b00));
        size     = SIZE_WORD;
        wstrb    = 4'b0000;
        wdata    = 32'h0000_0000;
        case (1'b1)
            memop[MMOP_LB], memop[MMOP_LBU]: size = SIZE_BYTE;
            memop[MMOP_LH], memop[MMOP_LHU]: size = SIZE_HALF;
            memop[MMOP_SB]: begin
                size  = SIZE_BYTE;
                wstrb = 4'b0001 << low_s;
                wdata = {4{rt[7:0]}};
            end
            memop[MMOP_SH]: begin
                size  = SIZE_HALF;
                wstrb = 4'b0011 << low_s;
                wdata = {2{rt[15:0]}};
            end
            memop[MMOP_SW]: begin
                wstrb = 4'b1111;
                wdata = rt;
            end
            // swl writes the high bytes of rt into the low lanes up to addr.
            memop[MMOP_SWL]: begin
                wstrb = 4'b1111 >> (2'd3 - low_s);
                wdata = rt >> (5'd24 - {low_s, 3'b000});
            end
            memop[MMOP_SWR]: begin
                wstrb = 4'b1111 << low_s;
                wdata = rt << {low_s, 3'b000};
            end
            default: begin
                size  = SIZE_WORD;
                wstrb = 4'b0000;
                wdata = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_req.sv
// Data-memory request FSM between EXE and MEM: issues one SRAM-like access at
// a time, waits for its data, and hands the result to MEM.
module mem_req
    import mem_req_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_valid_i,
    input  logic [11:0] exe_memop_i,
    input  logic [31:0] exe_memaddr_i,
    input  logic [31:0] exe_storedata_i,
    input  logic        exe_flush_i,
    input  logic        mem_stall_i,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_wstrb_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] mem_memdata_o,
    output logic [1:0]  mem_memaddr_low_o,
    output logic [11:0] mem_memop_o,
    output logic        mem_valid_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] badvaddr_o,
    output logic        memreq_stall_o
);

    state_e      state_r, state_s;
    logic        cancel_r, cancel_s;
    logic        latch_req_s, latch_data_s, stall_s, valid_s, cancel_eff_s;
    logic        present_s, accept_s;
    logic [11:0] op_r;
    logic [31:0] addr_r, wdata_r, memdata_r;
    logic [1:0]  low_r, size_r;
    logic [3:0]  wstrb_r;
    logic        wr_r;
    logic        sa_wr_s, sa_adel_s, sa_ades_s;
    logic [1:0]  sa_size_s;
    logic [31:0] sa_addr_s, sa_wdata_s;
    logic [3:0]  sa_wstrb_s;

    store_align u_store_align (
        .memop    (exe_memop_i),
        .addr     (exe_memaddr_i),
        .rt       (exe_storedata_i),
        .wr       (sa_wr_s),
        .size     (sa_size_s),
        .bus_addr (sa_addr_s),
        .wstrb    (sa_wstrb_s),
        .wdata    (sa_wdata_s),
        .adel     (sa_adel_s),
        .ades     (sa_ades_s)
    );

    // A flush arriving in the same cycle as the response still cancels it.
    assign cancel_eff_s = cancel_r | exe_flush_i;
    assign present_s    = (state_r == ST_IDLE) & exe_valid_i & (exe_memop_i != 12'h000) & ~exe_flush_i;
    assign accept_s     = present_s & ~sa_adel_s & ~sa_ades_s;

    // Next-state and per-state control.
    always_comb begin
        state_s      = state_r;
        cancel_s     = cancel_r;
        latch_req_s  = 1'b0;
        latch_data_s = 1'b0;
        stall_s      = 1'b0;
        valid_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cancel_s = 1'b0;
                if (accept_s) begin
                    state_s     = ST_REQ;
                    latch_req_s = 1'b1;
                    stall_s     = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                if (data_addr_ok_i & data_data_ok_i) begin
                    state_s      = cancel_eff_s ? ST_IDLE : ST_DONE;
                    latch_data_s = ~cancel_eff_s;
                    cancel_s     = 1'b0;
                end else if (data_addr_ok_i) begin
                    state_s  = ST_WAIT;
                    cancel_s = cancel_eff_s;
                end else begin
                    cancel_s = cancel_eff_s;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (data_data_ok_i) begin
                    state_s      = cancel_eff_s ? ST_IDLE : ST_DONE;
                    latch_data_s = ~cancel_eff_s;
                    cancel_s     = 1'b0;
                end else begin
                    cancel_s = cancel_eff_s;
                end
            end
            ST_DONE: begin
                valid_s = ~exe_flush_i;
                if (exe_flush_i | ~mem_stall_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                cancel_s = 1'b0;
            end
        endcase
    end

    // State, cancel flag and latched request/response fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cancel_r  <= 1'b0;
            op_r      <= 12'h000;
            addr_r    <= 32'h0000_0000;
            low_r     <= 2'b00;
            size_r    <= 2'b00;
            wr_r      <= 1'b0;
            wstrb_r   <= 4'b0000;
            wdata_r   <= 32'h0000_0000;
            memdata_r <= 32'h0000_0000;
        end else begin
            state_r  <= state_s;
            cancel_r <= cancel_s;
            if (latch_req_s) begin
                op_r    <= exe_memop_i;
                addr_r  <= sa_addr_s;
                low_r   <= exe_memaddr_i[1:0];
                size_r  <= sa_size_s;
                wr_r    <= sa_wr_s;
                wstrb_r <= sa_wstrb_s;
                wdata_r <= sa_wdata_s;
            end
            if (latch_data_s) begin
                memdata_r <= data_rdata_i;
            end
        end
    end

    assign data_req_o        = ~rst & (state_r == ST_REQ);
    assign data_wr_o         = wr_r;
    assign data_size_o       = size_r;
    assign data_addr_o       = addr_r;
    assign data_wstrb_o      = wstrb_r;
    assign data_wdata_o      = wdata_r;
    assign mem_memdata_o     = memdata_r;
    assign mem_memaddr_low_o = low_r;
    assign mem_memop_o       = op_r;
    assign mem_valid_o       = ~rst & valid_s;
    assign memreq_stall_o    = ~rst & stall_s;
    assign adel_o            = ~rst & present_s & sa_adel_s;
    assign ades_o            = ~rst & present_s & sa_ades_s;
    assign badvaddr_o        = (adel_o | ades_o) ? exe_memaddr_i : 32'h0000_0000;

endmodule

// File: tb/tb_mem_req.sv
// Scoreboard bench for mem_req: a driver issues randomized accesses and acts as
// the SRAM slave; a monitor checks every request, exception and MEM result.
module tb_mem_req;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid_i, exe_flush_i, mem_stall_i;
    logic [11:0] exe_memop_i;
    logic [31:0] exe_memaddr_i, exe_storedata_i;
    logic        data_req_o, data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_wstrb_o;
    logic        data_addr_ok_i, data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic [31:0] mem_memdata_o, badvaddr_o;
    logic [1:0]  mem_memaddr_low_o;
    logic [11:0] mem_memop_o;
    logic        mem_valid_o, adel_o, ades_o, memreq_stall_o;

    int vectors = 0;
    int miscompares = 0;

    logic [70:0] req_q[$];
    logic [32:0] exc_q[$];
    logic [45:0] res_q[$];

    mem_req dut (
        .clk(clk), .rst(rst),
        .exe_valid_i(exe_valid_i), .exe_memop_i(exe_memop_i),
        .exe_memaddr_i(exe_memaddr_i), .exe_storedata_i(exe_storedata_i),
        .exe_flush_i(exe_flush_i), .mem_stall_i(mem_stall_i),
        .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
        .data_addr_o(data_addr_o), .data_wstrb_o(data_wstrb_o), .data_wdata_o(data_wdata_o),
        .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
        .data_rdata_i(data_rdata_i),
        .mem_memdata_o(mem_memdata_o), .mem_memaddr_low_o(mem_memaddr_low_o),
        .mem_memop_o(mem_memop_o), .mem_valid_o(mem_valid_o),
        .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o),
        .memreq_stall_o(memreq_stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: expected request {wr, size, addr, wstrb, wdata} from the ISA rules.
    function automatic void model(input int op, input logic [31:0] addr, input logic [31:0] rt,
                                  output logic [70:0] req, output logic ade, output logic st);
        int          low;
        longint      scale, div;
        logic [3:0]  strb;
        logic [31:0] wd, ad;
        logic [1:0]  sz;
        logic [63:0] prod;
        low   = int'(addr % 32'd4);
        scale = 1;
        for (int i = 0; i < low; i++) scale = scale * 256;
        div = 1;
        for (int i = 0; i < 3 - low; i++) div = div * 256;
        st  = (op == 5 || op == 6 || op == 7 || op == 10 || op == 11);
        sz  = (op == 0 || op == 1 || op == 5) ? 2'd0 : (op == 2 || op == 3 || op == 6) ? 2'd1 : 2'd2;
        ade = ((op == 2 || op == 3 || op == 6) && (addr % 32'd2 != 32'd0)) ||
              ((op == 4 || op == 7) && (addr % 32'd4 != 32'd0));
        ad  = (op >= 8) ? addr - 32'(low) : addr;
        strb = 4'b0000;
        wd   = 32'h0;
        case (op)
            5: begin strb[low] = 1'b1; wd = 32'(rt[7:0]) * 32'h0101_0101; end
            6: begin strb[low] = 1'b1; strb[(low + 1) % 4] = 1'b1; wd = 32'(rt[15:0]) * 32'h0001_0001; end
            7: begin strb = 4'b1111; wd = rt; end
            10: begin
                for (int i = 0; i <= low; i++) strb[i] = 1'b1;
                wd = 32'(longint'(rt) / div);
            end
            11: begin
                for (int i = low; i < 4; i++) strb[i] = 1'b1;
                prod = 64'(longint'(rt) * scale);
                wd = prod[31:0];
            end
            default: begin strb = 4'b0000; wd = 32'h0; end
        endcase
        req = {st, sz, ad, strb, wd};
    endfunction

    task automatic step_chk(input logic exp_stall);
        @(negedge clk);
        check("stall", 160'(memreq_stall_o), 160'(exp_stall));
        @(posedge clk); #1;
    endtask

    task automatic chk_zero(input string name);
        check(name, 160'({data_req_o, data_wr_o, data_size_o, data_addr_o, data_wstrb_o, data_wdata_o,
                          mem_memdata_o, mem_memaddr_low_o, mem_memop_o, mem_valid_o, adel_o, ades_o,
                          badvaddr_o, memreq_stall_o}), 160'd0);
    endtask

    // One access: a = REQ cycles before addr_ok, both = addr_ok+data_ok together,
    // d = WAIT cycles before data_ok, flush_cyc = cycle index after acceptance (-1 none).
    task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rdata, input int a, input bit both, input int d,
                          input int flush_cyc, input int stalls, input bit flush_done);
        logic [70:0] r;
        logic        ade, st;
        logic [11:0] one;
        int          cyc;
        bit          cancelled;
        one = 12'd1;
        model(op, addr, rt, r, ade, st);
        exe_valid_i     = 1'b1;
        exe_memop_i     = one << op;
        exe_memaddr_i   = addr;
        exe_storedata_i = rt;
        if (ade) exc_q.push_back({st, addr});
        else     req_q.push_back(r);
        step_chk(!ade);
        exe_valid_i     = 1'b0;
        exe_memop_i     = 12'h000;
        exe_memaddr_i   = $urandom;
        exe_storedata_i = $urandom;
        if (ade) return;
        cancelled = (flush_cyc >= 0);
        cyc = 0;
        for (int i = 0; i < a; i++) begin
            exe_flush_i = (cyc == flush_cyc);
            step_chk(1'b1);
            cyc++;
        end
        data_addr_ok_i = 1'b1;
        data_data_ok_i = both;
        data_rdata_i   = rdata;
        exe_flush_i    = (cyc == flush_cyc);
        if (both && !cancelled && !flush_done) res_q.push_back({rdata, addr[1:0], one << op});
        step_chk(1'b1);
        cyc++;
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        data_rdata_i   = $urandom;
        if (!both) begin
            for (int i = 0; i < d; i++) begin
                exe_flush_i = (cyc == flush_cyc);
                step_chk(1'b1);
                cyc++;
            end
            exe_flush_i    = 1'b0;
            data_data_ok_i = 1'b1;
            data_rdata_i   = rdata;
            if (!cancelled && !flush_done) res_q.push_back({rdata, addr[1:0], one << op});
            step_chk(1'b1);
            data_data_ok_i = 1'b0;
            data_rdata_i   = $urandom;
        end
        exe_flush_i = 1'b0;
        if (cancelled) return;
        if (flush_done) begin
            exe_flush_i = 1'b1;
            mem_stall_i = 1'($urandom_range(1));
            step_chk(1'b0);
            exe_flush_i = 1'b0;
            mem_stall_i = 1'b0;
            return;
        end
        for (int i = 0; i < stalls; i++) begin
            mem_stall_i = 1'b1;
            step_chk(1'b0);
        end
        mem_stall_i = 1'b0;
        step_chk(1'b0);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (data_req_o) begin
                if (req_q.size() == 0) check("req_spurious", 160'(data_req_o), 160'd0);
                else begin
                    check("req_fields", 160'({data_wr_o, data_size_o, data_addr_o, data_wstrb_o, data_wdata_o}),
                          160'(req_q[0]));
                    if (data_addr_ok_i) void'(req_q.pop_front());
                end
            end
            if (adel_o || ades_o) begin
                if (exc_q.size() == 0) check("exc_spurious", 160'({adel_o, ades_o}), 160'd0);
                else begin
                    check("exception", 160'({ades_o, adel_o, badvaddr_o}),
                          160'({exc_q[0][32], !exc_q[0][32], exc_q[0][31:0]}));
                    void'(exc_q.pop_front());
                end
            end
            if (mem_valid_o) begin
                if (res_q.size() == 0) check("valid_spurious", 160'(mem_valid_o), 160'd0);
                else begin
                    check("mem_result", 160'({mem_memdata_o, mem_memaddr_low_o, mem_memop_o}), 160'(res_q[0]));
                    if (!mem_stall_i) void'(res_q.pop_front());
                end
            end
        end
    end

    initial begin
        int op, a, d, fc, mode;
        bit both;
        logic [31:0] addr;
        logic [70:0] r;
        logic        ade, st;
        rst = 1'b1; exe_valid_i = 1'b0; exe_memop_i = 12'h000; exe_memaddr_i = 32'h0;
        exe_storedata_i = 32'h0; exe_flush_i = 1'b0; mem_stall_i = 1'b0;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
        @(posedge clk); #1;
        exe_valid_i = 1'b1; exe_memop_i = 12'h010; exe_memaddr_i = 32'h8000_0002;
        @(negedge clk);
        chk_zero("reset_state");
        @(posedge clk); #1;
        rst = 1'b0; exe_valid_i = 1'b0; exe_memop_i = 12'h000;

        run_op(7, 32'h8000_1004, 32'h1122_3344, 32'h5555_6666, 1, 1'b0, 1, -1, 0, 1'b0);
        run_op(0, 32'h8000_0003, 32'h0, 32'hAABB_CCDD, 0, 1'b0, 0, -1, 0, 1'b0);
        run_op(10, 32'h8000_0001, 32'hA1B2_C3D4, 32'h0, 0, 1'b1, 0, -1, 0, 1'b0);
        run_op(4, 32'h8000_0002, 32'h0, 32'h0, 0, 1'b0, 0, -1, 0, 1'b0);
        run_op(4, 32'h8000_0040, 32'h0, 32'h1234_5678, 0, 1'b0, 3, 1, 0, 1'b0);
        run_op(4, 32'h8000_0044, 32'h0, 32'h9ABC_DEF0, 0, 1'b0, 0, -1, 0, 1'b0);
        run_op(4, 32'h8000_0048, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 1, -1, 4, 1'b0);
        run_op(6, 32'h8000_0005, 32'h0000_BEEF, 32'h0, 0, 1'b0, 0, -1, 0, 1'b0);

        // Reset in the middle of an access; the late response must be ignored.
        model(4, 32'h8000_0010, 32'h0, r, ade, st);
        req_q.push_back(r);
        exe_valid_i = 1'b1; exe_memop_i = 12'h010; exe_memaddr_i = 32'h8000_0010;
        step_chk(1'b1);
        exe_valid_i = 1'b0; exe_memop_i = 12'h000; data_addr_ok_i = 1'b1;
        step_chk(1'b1);
        data_addr_ok_i = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_zero("reset_mid");
        @(posedge clk); #1;
        rst = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
        step_chk(1'b0);
        data_data_ok_i = 1'b0;
        step_chk(1'b0);

        for (int n = 0; n < 200; n++) begin
            op   = int'($urandom_range(11));
            addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            if ($urandom_range(1) == 0) addr[1:0] = 2'b00;
            a    = int'($urandom_range(2));
            both = ($urandom_range(3) == 0);
            d    = int'($urandom_range(3));
            mode = int'($urandom_range(9));
            fc   = -1;
            if (mode >= 6 && mode < 8) begin
                if (!both) fc = int'($urandom_range(a + d));
                else if (a > 0) fc = int'($urandom_range(a - 1));
            end
            run_op(op, addr, $urandom, $urandom, a, both, d, fc, int'($urandom_range(3)), mode >= 8);
            if ($urandom_range(4) == 0) begin
                exe_valid_i = 1'($urandom_range(1));
                exe_memop_i = exe_valid_i ? 12'h000 : 12'(1 << $urandom_range(11));
                step_chk(1'b0);
                exe_valid_i = 1'b0; exe_memop_i = 12'h000;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("req_q_empty", 160'(req_q.size()), 160'd0);
        check("exc_q_empty", 160'(exc_q.size()), 160'd0);
        check("res_q_empty", 160'(res_q.size()), 160'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
